// File: rtl/pc_seq_pkg.sv
// Shared types for the next-PC sequencer: FSM states, the one-hot-per-cycle
// action chosen by the priority decode, and the decode helper itself.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_HALT = 2'd2
  } seq_state_e;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_HALT   = 3'd2,
    ACT_RET    = 3'd3,
    ACT_CALL   = 3'd4,
    ACT_JUMP   = 3'd5,
    ACT_BRANCH = 3'd6
  } action_e;

  // Fixed-priority pick of the single action taken this cycle while running.
  function automatic action_e decode_action(
    input logic stall,
    input logic halt_req,
    input logic ret_req,
    input logic call_req,
    input logic jump_req,
    input logic branch_go
  );
    action_e act;
    act = ACT_NONE;
    if (stall)         act = ACT_STALL;
    else if (halt_req) act = ACT_HALT;
    else if (ret_req)  act = ACT_RET;
    else if (call_req) act = ACT_CALL;
    else if (jump_req) act = ACT_JUMP;
    else if (branch_go) act = ACT_BRANCH;
    return act;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: circular storage with a saturating occupancy count.
// A push while full overwrites the oldest entry; the top always reflects the
// most recent push.
//   clk, reset_n    : clock, async active-low reset
//   push, push_data : store push_data as new top (wins over pop)
//   pop             : discard the top entry (ignored when empty)
//   top             : most recently pushed live entry
//   empty, full     : occupancy status
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned D         = 10,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [D-1:0] push_data,
  input  logic         pop,
  output logic [D-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [D-1:0]  mem [RAS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] top_idx;

  // wr_ptr points at the next free slot; power-of-two depth makes the wrap free.
  assign top_idx = wr_ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(RAS_DEPTH));

  // Storage, pointer and saturating count update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= PW'(0);
      count  <= CW'(0);
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem[i] <= D'(0);
      end
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr <= wr_ptr - PW'(1);
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: decides each cycle whether the PC increments or is
// redirected, with stall/halt freeze, relative branch, absolute jump and
// call/return through a small return-address stack.
//   clk, reset_n       : clock, async active-low reset
//   start              : leave IDLE
//   stall, halt_req    : freeze PC / stop execution
//   pc                 : current PC value
//   branch_*           : conditional relative branch (signed offset)
//   jump_req/addr      : absolute jump
//   call_req/addr      : call (push pc+1), ret_req: return (pop)
//   pc_jump_en/target  : combinational redirect to the PC register
//   running, halted    : state decode
//   ras_overflow/underflow : sticky RAS error flags
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D         = 10,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic [D-1:0]     pc,
  input  logic             branch_req,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             jump_req,
  input  logic [D-1:0]     jump_addr,
  input  logic             call_req,
  input  logic [D-1:0]     call_addr,
  input  logic             ret_req,
  input  logic             halt_req,
  output logic             pc_jump_en,
  output logic [D-1:0]     pc_target,
  output logic             running,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  seq_state_e   state_q, state_nx;
  action_e      action;
  logic [D-1:0] pc_plus1;
  logic [D-1:0] off_ext;
  logic [D-1:0] branch_tgt;
  logic         ras_push, ras_pop;
  logic [D-1:0] ras_top;
  logic         ras_empty, ras_full;
  logic         ovf_set, unf_set;

  // All target arithmetic wraps modulo 2^D.
  assign pc_plus1   = pc + D'(1);
  assign off_ext    = {{(D-OFF_W){branch_off[OFF_W-1]}}, branch_off};
  assign branch_tgt = pc + off_ext;

  assign running = (state_q == SEQ_RUN);
  assign halted  = (state_q == SEQ_HALT);

  ras_stack #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .push_data (pc_plus1),
    .pop       (ras_pop),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next state, priority decode and target mux; outside RUN the PC is frozen.
  always_comb begin
    state_nx   = state_q;
    action     = ACT_NONE;
    pc_jump_en = 1'b1;
    pc_target  = pc;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start) state_nx = SEQ_RUN;
      end
      SEQ_RUN: begin
        action = decode_action(stall, halt_req, ret_req, call_req, jump_req,
                               branch_req & branch_taken);
        case (action)
          ACT_STALL: ;
          ACT_HALT:  state_nx = SEQ_HALT;
          ACT_RET: begin
            if (ras_empty) begin
              pc_jump_en = 1'b0;
              pc_target  = pc_plus1;
              unf_set    = 1'b1;
            end else begin
              pc_target = ras_top;
              ras_pop   = 1'b1;
            end
          end
          ACT_CALL: begin
            pc_target = call_addr;
            ras_push  = 1'b1;
            ovf_set   = ras_full;
          end
          ACT_JUMP:   pc_target = jump_addr;
          ACT_BRANCH: pc_target = branch_tgt;
          default: begin
            pc_jump_en = 1'b0;
            pc_target  = pc_plus1;
          end
        endcase
      end
      SEQ_HALT: ;
      default: state_nx = SEQ_IDLE;
    endcase
  end

  // Sticky RAS error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (ovf_set) ras_overflow  <= 1'b1;
      if (unf_set) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected redirect outputs are queued
// as each cycle's stimulus is driven and popped/compared before the edge.
module tb_pc_sequencer;

  localparam int unsigned D         = 10;
  localparam int unsigned OFF_W     = 8;
  localparam int unsigned RAS_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start, stall, branch_req, branch_taken;
  logic [OFF_W-1:0] branch_off;
  logic [D-1:0]     pc, jump_addr, call_addr;
  logic             jump_req, call_req, ret_req, halt_req;
  logic             pc_jump_en;
  logic [D-1:0]     pc_target;
  logic             running, halted, ras_overflow, ras_underflow;

  pc_sequencer #(.D(D), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stall         (stall),
    .pc            (pc),
    .branch_req    (branch_req),
    .branch_taken  (branch_taken),
    .branch_off    (branch_off),
    .jump_req      (jump_req),
    .jump_addr     (jump_addr),
    .call_req      (call_req),
    .call_addr     (call_addr),
    .ret_req       (ret_req),
    .halt_req      (halt_req),
    .pc_jump_en    (pc_jump_en),
    .pc_target     (pc_target),
    .running       (running),
    .halted        (halted),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic         en;
    logic [D-1:0] tgt;
    logic         tgt_valid;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input logic en, input logic [D-1:0] tgt,
                            input logic tgt_valid);
    exp_t e;
    e.tag = tag; e.en = en; e.tgt = tgt; e.tgt_valid = tgt_valid;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic sample_outputs();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".en"}, 32'(pc_jump_en), 32'(e.en));
      if (e.tgt_valid) check_eq({e.tag, ".tgt"}, 32'(pc_target), 32'(e.tgt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample_outputs();
    tick();
  endtask

  task automatic clr_req();
    start = 0; stall = 0; branch_req = 0; branch_taken = 0; branch_off = '0;
    jump_req = 0; call_req = 0; ret_req = 0; halt_req = 0;
    jump_addr = '0; call_addr = '0;
  endtask

  task automatic do_call(input string tag, input logic [D-1:0] p, input logic [D-1:0] a);
    clr_req(); pc = p; call_req = 1; call_addr = a;
    expect_out(tag, 1'b1, a, 1'b1);
    step();
  endtask

  task automatic do_ret(input string tag, input logic [D-1:0] p, input logic en,
                        input logic [D-1:0] tgt);
    clr_req(); pc = p; ret_req = 1;
    expect_out(tag, en, tgt, en);
    step();
  endtask

  task automatic go_run();
    clr_req(); start = 1; step();
    clr_req();
  endtask

  initial begin
    clr_req();
    pc = 10'd37;
    reset_n = 1'b0;
    // Reset state
    expect_out("rst", 1'b1, 10'd37, 1'b1);
    sample_outputs();
    check_eq("rst.running", 32'(running), 32'd0);
    check_eq("rst.halted", 32'(halted), 32'd0);
    check_eq("rst.ovf", 32'(ras_overflow), 32'd0);
    check_eq("rst.unf", 32'(ras_underflow), 32'd0);
    tick();
    reset_n = 1'b1;
    expect_out("idle", 1'b1, 10'd37, 1'b1);
    step();
    start = 1;
    expect_out("idle_start", 1'b1, 10'd37, 1'b1);
    step();
    check_eq("run.running", 32'(running), 32'd1);

    clr_req(); pc = 10'd38;
    expect_out("seq", 1'b0, 10'd39, 1'b1);
    step();

    // Branch wrap and not-taken
    clr_req(); pc = 10'd2; branch_req = 1; branch_taken = 1; branch_off = 8'hFC;
    expect_out("br_wrap", 1'b1, 10'd1022, 1'b1);
    step();
    clr_req(); pc = 10'd2; branch_req = 1; branch_taken = 0; branch_off = 8'hFC;
    expect_out("br_nt", 1'b0, 10'd3, 1'b1);
    step();
    clr_req(); pc = 10'd1000; branch_req = 1; branch_taken = 1; branch_off = 8'd40;
    expect_out("br_fwd_wrap", 1'b1, 10'd16, 1'b1);
    step();
    clr_req(); pc = 10'd5; jump_req = 1; jump_addr = 10'd777;
    expect_out("jump", 1'b1, 10'd777, 1'b1);
    step();

    // Call / return / underflow
    do_call("call", 10'd100, 10'd500);
    do_ret("ret", 10'd510, 1'b1, 10'd101);
    do_ret("ret_empty", 10'd510, 1'b0, 10'd0);
    check_eq("unf.set", 32'(ras_underflow), 32'd1);
    clr_req(); pc = 10'd600;
    expect_out("idle2", 1'b0, 10'd601, 1'b1);
    step();
    check_eq("unf.sticky", 32'(ras_underflow), 32'd1);

    // Overflow: pc=1023 call pushes 0 is covered by wrap below
    for (int i = 1; i <= 4; i++) do_call("nest", D'(i * 10), 10'd200);
    check_eq("ovf.not_yet", 32'(ras_overflow), 32'd0);
    do_call("nest5", 10'd50, 10'd200);
    check_eq("ovf.set", 32'(ras_overflow), 32'd1);
    do_ret("ret51", 10'd201, 1'b1, 10'd51);
    do_ret("ret41", 10'd201, 1'b1, 10'd41);
    do_ret("ret31", 10'd201, 1'b1, 10'd31);
    do_ret("ret21", 10'd201, 1'b1, 10'd21);
    do_ret("ret_5th", 10'd201, 1'b0, 10'd0);

    do_call("call_wrap", 10'd1023, 10'd4);
    do_ret("ret_wrap", 10'd9, 1'b1, 10'd0);

    // Priority collisions
    do_call("call300", 10'd300, 10'd700);
    clr_req(); pc = 10'd77; stall = 1; halt_req = 1; call_req = 1; call_addr = 10'd444;
    expect_out("stall_pri", 1'b1, 10'd77, 1'b1);
    step();
    check_eq("stall.running", 32'(running), 32'd1);
    clr_req(); pc = 10'd80; ret_req = 1; call_req = 1; call_addr = 10'd555;
    expect_out("ret_over_call", 1'b1, 10'd301, 1'b1);
    step();
    do_ret("ret_after_pop", 10'd81, 1'b0, 10'd0);
    do_call("call400", 10'd400, 10'd800);
    clr_req(); pc = 10'd90; halt_req = 1; call_req = 1; call_addr = 10'd123;
    expect_out("halt_pri", 1'b1, 10'd90, 1'b1);
    step();
    check_eq("halt.halted", 32'(halted), 32'd1);
    check_eq("halt.running", 32'(running), 32'd0);
    clr_req(); pc = 10'd91; start = 1; jump_req = 1; jump_addr = 10'd3;
    expect_out("halt_freeze", 1'b1, 10'd91, 1'b1);
    step();
    check_eq("halt.stays", 32'(halted), 32'd1);
    check_eq("halt.ovf", 32'(ras_overflow), 32'd1);
    check_eq("halt.unf", 32'(ras_underflow), 32'd1);

    // Reset out of HALT clears everything
    clr_req(); pc = 10'd200; reset_n = 1'b0;
    #1;
    check_eq("rst2.halted", 32'(halted), 32'd0);
    check_eq("rst2.ovf", 32'(ras_overflow), 32'd0);
    check_eq("rst2.unf", 32'(ras_underflow), 32'd0);
    expect_out("rst2", 1'b1, 10'd200, 1'b1);
    step();
    reset_n = 1'b1;
    go_run();
    do_ret("ret_empty2", 10'd3, 1'b0, 10'd0);
    check_eq("unf2.set", 32'(ras_underflow), 32'd1);

    // Reset asserted mid-call, before the push edge
    clr_req(); pc = 10'd5; call_req = 1; call_addr = 10'd600;
    expect_out("midcall", 1'b1, 10'd600, 1'b1);
    sample_outputs();
    reset_n = 1'b0;
    #1;
    check_eq("midrst.running", 32'(running), 32'd0);
    check_eq("midrst.unf", 32'(ras_underflow), 32'd0);
    check_eq("midrst.en", 32'(pc_jump_en), 32'd1);
    check_eq("midrst.tgt", 32'(pc_target), 32'd5);
    tick();
    reset_n = 1'b1;
    go_run();
    do_ret("ret_after_rst", 10'd7, 1'b0, 10'd0);
    check_eq("unf3.set", 32'(ras_underflow), 32'd1);
    check_eq("ovf3.clear", 32'(ras_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
